// File: rtl/eq_bank_tdm_pkg.sv
// ----------------------------------------------------------------------------
// | Package     : eq_bank_tdm_pkg                                            |
// | Description : FSM state encodings and shared saturation helper for the   |
// |               time-multiplexed equalizer bank.                           |
// | Revision    : 1.0                                                        |
// ----------------------------------------------------------------------------
`default_nettype none

package eq_bank_tdm_pkg;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_MAC   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SCALE = 3'd2;
  localparam logic [STATE_W-1:0] ST_SUM   = 3'd3;
  localparam logic [STATE_W-1:0] ST_OUT   = 3'd4;

  // Every intermediate is sign-extended to this width before clamping.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_to(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_to = hi;
    else if (v < lo) sat_to = lo;
    else             sat_to = v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eq_bank_tdm_fir_mac_lane.sv
// ----------------------------------------------------------------------------
// | Module      : eq_bank_tdm_fir_mac_lane                                   |
// | Description : One FIR band: coefficient RAM, accumulator, output         |
// |               saturation and fractional gain stage.                      |
// | Revision    : 1.0                                                        |
// ----------------------------------------------------------------------------
`default_nettype none

module eq_bank_tdm_fir_mac_lane
  import eq_bank_tdm_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int NUM_TAPS  = 64,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coef_we_i,
  input  logic [$clog2(NUM_TAPS)-1:0]       coef_addr_i,
  input  logic signed [COEF_W-1:0]          coef_wdata_i,
  input  logic                              mac_en_i,
  input  logic [$clog2(NUM_TAPS)-1:0]       tap_i,
  input  logic signed [IN_W-1:0]            x_i,
  input  logic                              scale_en_i,
  input  logic signed [GAIN_W-1:0]          gain_i,
  output logic signed [OUT_W-1:0]           band_o
);

  localparam int TAP_AW  = $clog2(NUM_TAPS);
  localparam int PROD_W  = IN_W + COEF_W;
  localparam int ACC_W   = PROD_W + TAP_AW;
  localparam int GPROD_W = OUT_W + GAIN_W;

  logic signed [COEF_W-1:0]  coef_mem [NUM_TAPS];
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [OUT_W-1:0]   w_y;
  logic signed [GPROD_W-1:0] w_gprod;
  logic signed [OUT_W-1:0]   w_g;
  logic signed [OUT_W-1:0]   band_q;

  // Coefficients survive reset, so this RAM has no reset branch.
  always_ff @(posedge clk) begin
    if (coef_we_i) coef_mem[coef_addr_i] <= coef_wdata_i;
  end

  assign w_prod     = x_i * coef_mem[tap_i];
  assign w_prod_ext = ACC_W'(w_prod);
  assign acc_d      = (tap_i == '0) ? w_prod_ext : acc_q + w_prod_ext;

  assign w_y     = OUT_W'(sat_to(SAT_W'(acc_q >>> COEF_FRAC), OUT_W));
  assign w_gprod = w_y * gain_i;
  assign w_g     = OUT_W'(sat_to(SAT_W'(w_gprod >>> GAIN_FRAC), OUT_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      band_q <= '0;
    end else begin
      if (mac_en_i)   acc_q  <= acc_d;
      if (scale_en_i) band_q <= w_g;
    end
  end

  assign band_o = band_q;

endmodule

`default_nettype wire

// File: rtl/eq_bank_tdm.sv
// ----------------------------------------------------------------------------
// | Module      : eq_bank_tdm                                                |
// | Description : Multi-band FIR equalizer sharing one delay line, with      |
// |               per-band gains, saturating sum, bypass and handshakes.     |
// | Revision    : 1.0                                                        |
// ----------------------------------------------------------------------------
`default_nettype none

module eq_bank_tdm
  import eq_bank_tdm_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int NUM_BANDS = 8,
  parameter int NUM_TAPS  = 64,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic signed [IN_W-1:0]                 in_data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic signed [OUT_W-1:0]                out_data_o,
  output logic [NUM_BANDS*OUT_W-1:0]             band_data_o,
  input  logic [NUM_BANDS*GAIN_W-1:0]            gains_i,
  input  logic                                   bypass_i,
  input  logic                                   coef_we_i,
  input  logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] coef_band_i,
  input  logic [$clog2(NUM_TAPS)-1:0]            coef_addr_i,
  input  logic signed [COEF_W-1:0]               coef_wdata_i,
  output logic                                   coef_err_o
);

  localparam int TAP_AW  = $clog2(NUM_TAPS);
  localparam int BAND_AW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int SUM_W   = OUT_W + $clog2(NUM_BANDS);

  logic [STATE_W-1:0]          state_q;
  logic [STATE_W-1:0]          state_d;
  logic signed [IN_W-1:0]      line_q [NUM_TAPS];
  logic [TAP_AW-1:0]           wr_ptr_q;
  logic [TAP_AW-1:0]           base_q;
  logic [TAP_AW-1:0]           tap_q;
  logic [NUM_BANDS*GAIN_W-1:0] gains_q;
  logic                        bypass_q;
  logic signed [IN_W-1:0]      in_lat_q;
  logic signed [OUT_W-1:0]     out_data_q;
  logic                        coef_err_q;

  logic                        w_idle;
  logic                        w_mac_en;
  logic                        w_scale_en;
  logic                        w_sum_en;
  logic                        w_accept;
  logic                        w_coef_ok;
  logic signed [IN_W-1:0]      w_x;
  logic signed [OUT_W-1:0]     w_band [NUM_BANDS];
  logic signed [SUM_W-1:0]     w_sum;
  logic signed [OUT_W-1:0]     w_sum_sat;
  logic signed [OUT_W-1:0]     w_byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid_i) state_d = ST_MAC;
      ST_MAC:   if (tap_q == TAP_AW'(NUM_TAPS - 1)) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_SUM;
      ST_SUM:   state_d = ST_OUT;
      ST_OUT:   if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_idle      = 1'b0;
    out_valid_o = 1'b0;
    w_mac_en    = 1'b0;
    w_scale_en  = 1'b0;
    w_sum_en    = 1'b0;
    case (state_q)
      ST_IDLE:  w_idle      = 1'b1;
      ST_MAC:   w_mac_en    = 1'b1;
      ST_SCALE: w_scale_en  = 1'b1;
      ST_SUM:   w_sum_en    = 1'b1;
      ST_OUT:   out_valid_o = 1'b1;
      default:  w_idle      = 1'b0;
    endcase
  end

  assign in_ready_o = w_idle;
  assign w_accept   = w_idle && in_valid_i;
  // A write colliding with a sample accept loses, keeping the sample's taps consistent.
  assign w_coef_ok  = coef_we_i && w_idle && !in_valid_i;

  assign w_x = line_q[base_q - tap_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      base_q     <= '0;
      tap_q      <= '0;
      gains_q    <= '0;
      bypass_q   <= 1'b0;
      in_lat_q   <= '0;
      out_data_q <= '0;
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= coef_we_i && !w_coef_ok;
      if (w_accept) begin
        line_q[wr_ptr_q] <= in_data_i;
        base_q           <= wr_ptr_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        tap_q            <= '0;
        gains_q          <= gains_i;
        bypass_q         <= bypass_i;
        in_lat_q         <= in_data_i;
      end
      if (w_mac_en) tap_q <= tap_q + 1'b1;
      if (w_sum_en) out_data_q <= bypass_q ? w_byp : w_sum_sat;
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_lane
      eq_bank_tdm_fir_mac_lane #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .NUM_TAPS  (NUM_TAPS),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
      ) u_lane (
        .clk          (clk),
        .rst          (rst),
        .coef_we_i    (w_coef_ok && (coef_band_i == BAND_AW'(b))),
        .coef_addr_i  (coef_addr_i),
        .coef_wdata_i (coef_wdata_i),
        .mac_en_i     (w_mac_en),
        .tap_i        (tap_q),
        .x_i          (w_x),
        .scale_en_i   (w_scale_en),
        .gain_i       (gains_q[b*GAIN_W +: GAIN_W]),
        .band_o       (w_band[b])
      );
      assign band_data_o[b*OUT_W +: OUT_W] = w_band[b];
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_BANDS; i++) w_sum = w_sum + SUM_W'(w_band[i]);
  end

  assign w_sum_sat = OUT_W'(sat_to(SAT_W'(w_sum), OUT_W));
  assign w_byp     = OUT_W'(sat_to(SAT_W'(in_lat_q), OUT_W));

  assign out_data_o = out_data_q;
  assign coef_err_o = coef_err_q;

endmodule

`default_nettype wire

// File: tb/tb_eq_bank_tdm.sv
// ----------------------------------------------------------------------------
// | Module      : tb_eq_bank_tdm                                             |
// | Description : Scoreboard bench for eq_bank_tdm with a behavioural model. |
// | Revision    : 1.0                                                        |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_eq_bank_tdm;

  localparam int IN_W = 16, OUT_W = 16, NB = 8, NT = 64;
  localparam int COEF_W = 16, COEF_FRAC = 15, GAIN_W = 8, GAIN_FRAC = 6;
  localparam int TAP_AW = $clog2(NT), BAND_AW = $clog2(NB);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic signed [IN_W-1:0]   in_data_i;
  logic signed [OUT_W-1:0]  out_data_o;
  logic [NB*OUT_W-1:0]      band_data_o;
  logic [NB*GAIN_W-1:0]     gains_i;
  logic                     bypass_i, coef_we_i, coef_err_o;
  logic [BAND_AW-1:0]       coef_band_i;
  logic [TAP_AW-1:0]        coef_addr_i;
  logic signed [COEF_W-1:0] coef_wdata_i;

  typedef struct {
    longint out;
    longint band0;
  } exp_t;

  exp_t   sb[$];
  longint line_m [NT];
  longint coef_m [NB][NT];
  int     wp_m;
  int     n_checks = 0;
  int     n_errors = 0;

  eq_bank_tdm #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_BANDS(NB), .NUM_TAPS(NT),
    .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .band_data_o(band_data_o), .gains_i(gains_i), .bypass_i(bypass_i),
    .coef_we_i(coef_we_i), .coef_band_i(coef_band_i), .coef_addr_i(coef_addr_i),
    .coef_wdata_i(coef_wdata_i), .coef_err_o(coef_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint sat_m(input longint v);
    longint lim;
    lim = longint'(1) << (OUT_W - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
  endfunction

  function automatic longint band0_out();
    return longint'($signed(band_data_o[OUT_W-1:0]));
  endfunction

  task automatic model_accept(input longint x, input bit bp, output exp_t e);
    longint acc, y, g, sum, gn;
    line_m[wp_m] = x;
    sum = 0;
    e.band0 = 0;
    for (int b = 0; b < NB; b++) begin
      acc = 0;
      for (int k = 0; k < NT; k++) acc += line_m[(wp_m - k + NT) % NT] * coef_m[b][k];
      y  = sat_m(acc >>> COEF_FRAC);
      gn = longint'($signed(gains_i[b*GAIN_W +: GAIN_W]));
      g  = sat_m((y * gn) >>> GAIN_FRAC);
      if (b == 0) e.band0 = g;
      sum += g;
    end
    e.out = bp ? sat_m(x) : sat_m(sum);
    wp_m = (wp_m + 1) % NT;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NT; k++) line_m[k] = 0;
    wp_m = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic wr_coef(input int b, input int a, input int v);
    coef_we_i    = 1'b1;
    coef_band_i  = BAND_AW'(b);
    coef_addr_i  = TAP_AW'(a);
    coef_wdata_i = COEF_W'(v);
    @(negedge clk);
    coef_we_i = 1'b0;
    coef_m[b][a] = longint'($signed(COEF_W'(v)));
  endtask

  task automatic load_bank(input int mode);
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < NT; k++)
        case (mode)
          0: wr_coef(b, k, (b == 0) ? k * 256 : 0);
          1: wr_coef(b, k, (k == 0) ? 32767 : 0);
          default: wr_coef(b, k, (b == 0 && k == 5) ? 32767 : 0);
        endcase
  endtask

  // inj: 0 none, 1 coef write in the accept cycle, 2 coef write + stray sample during MAC
  task automatic run_sample(input int x, input bit bp, input int stall, input int inj);
    exp_t e;
    int c;
    logic signed [OUT_W-1:0] held;
    c = 0;
    while (!in_ready_o && c < 200) begin @(negedge clk); c++; end
    check_val("in_ready_wait", longint'(in_ready_o), 1);
    in_valid_i = 1'b1;
    in_data_i  = IN_W'(x);
    bypass_i   = bp;
    if (inj == 1) begin
      coef_we_i = 1'b1; coef_band_i = '0; coef_addr_i = TAP_AW'(1); coef_wdata_i = 16'sh1234;
    end
    model_accept(longint'(x), bp, e);
    sb.push_back(e);
    @(negedge clk);
    in_valid_i = 1'b0;
    coef_we_i  = 1'b0;
    c = 1;
    if (inj == 1) check_val("coef_err_accept", longint'(coef_err_o), 1);
    if (inj == 2) begin
      check_val("in_ready_busy", longint'(in_ready_o), 0);
      in_valid_i = 1'b1; in_data_i = 16'sd999;
      coef_we_i = 1'b1; coef_band_i = '0; coef_addr_i = TAP_AW'(1); coef_wdata_i = 16'sh1234;
      @(negedge clk); c++;
      in_valid_i = 1'b0; coef_we_i = 1'b0;
      check_val("coef_err_mac", longint'(coef_err_o), 1);
      @(negedge clk); c++;
      check_val("coef_err_once", longint'(coef_err_o), 0);
    end
    while (!out_valid_o && c < 300) begin @(negedge clk); c++; end
    check_val("latency", c, NT + 3);
    held = out_data_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val("stall_data", longint'(out_data_o), longint'(held));
      check_val("stall_in_ready", longint'(in_ready_o), 0);
      check_val("stall_valid", longint'(out_valid_o), 1);
    end
    if (sb.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_val("out_data", longint'(out_data_o), e.out);
      check_val("band0", band0_out(), e.band0);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check_val("valid_drop", longint'(out_valid_o), 0);
    check_val("in_ready_back", longint'(in_ready_o), 1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    gains_i = '0; bypass_i = 1'b0; coef_we_i = 1'b0; coef_band_i = '0;
    coef_addr_i = '0; coef_wdata_i = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_in_ready", longint'(in_ready_o), 1);
    check_val("rst_out_valid", longint'(out_valid_o), 0);
    check_val("rst_out_data", longint'(out_data_o), 0);
    check_val("rst_band_data", longint'(band_data_o == '0), 1);
    check_val("rst_coef_err", longint'(coef_err_o), 0);

    // Impulse through band0 with coef[k] = k*256 and unity gain.
    load_bank(0);
    gains_i = '0;
    gains_i[GAIN_W-1:0] = 8'h40;
    run_sample(32767, 1'b0, 10, 0);
    for (int k = 1; k < 16; k++) run_sample(0, 1'b0, 0, 0);

    // Reset mid-MAC, then the impulse must replay as after a fresh reset.
    in_valid_i = 1'b1; in_data_i = 16'sd12345;
    model_accept(12345, 1'b0, e);
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_valid", longint'(out_valid_o), 0);
    check_val("midrst_in_ready", longint'(in_ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check_val("midrst_out_data", longint'(out_data_o), 0);
    check_val("midrst_band_data", longint'(band_data_o == '0), 1);
    for (int k = 0; k < 8; k++) run_sample((k == 0) ? 32767 : 0, 1'b0, 0, 0);

    // Rejected writes leave coef[0][1] at 256; then an idle write takes effect.
    run_sample(5, 1'b0, 0, 2);
    run_sample(7, 1'b0, 0, 1);
    do_reset();
    run_sample(32767, 1'b0, 0, 0);
    run_sample(0, 1'b0, 0, 0);
    do_reset();
    wr_coef(0, 1, 16'h4000);
    check_val("coef_err_idle", longint'(coef_err_o), 0);
    run_sample(32767, 1'b0, 0, 0);
    run_sample(0, 1'b0, 0, 0);

    // Saturation at both rails, plus bypass.
    load_bank(1);
    gains_i = {NB{8'h7F}};
    run_sample(32767, 1'b0, 0, 0);
    run_sample(-32768, 1'b0, 0, 0);
    run_sample(-1234, 1'b1, 0, 0);
    run_sample(100, 1'b0, 0, 0);

    // Pure 5-sample delay over three laps of the delay line.
    load_bank(2);
    gains_i = '0;
    gains_i[GAIN_W-1:0] = 8'h40;
    do_reset();
    for (int i = 0; i < 3 * NT; i++) run_sample(-30000 + i * 311, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
